// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF port, DM port and shared memory port signals for mem_port_arbiter.
// The slave modport belongs to the arbiter. The master modport belongs to the core/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  i_if_req;
    logic [ADDR_W-1:0]     i_if_addr;
    logic                  o_if_valid;
    logic [DATA_W-1:0]     o_if_rdata;
    logic                  o_if_stall;
    logic                  i_flush;

    logic                  i_dm_req;
    logic                  i_dm_we;
    logic [ADDR_W-1:0]     i_dm_addr;
    logic [DATA_W-1:0]     i_dm_wdata;
    logic [DATA_W/8-1:0]   i_dm_be;
    logic                  o_dm_valid;
    logic [DATA_W-1:0]     o_dm_rdata;
    logic                  o_dm_stall;

    logic                  o_mem_req;
    logic                  o_mem_we;
    logic [ADDR_W-1:0]     o_mem_addr;
    logic [DATA_W-1:0]     o_mem_wdata;
    logic [DATA_W/8-1:0]   o_mem_be;
    logic                  i_mem_ready;
    logic                  i_mem_rvalid;
    logic [DATA_W-1:0]     i_mem_rdata;

    modport slave (
        input  i_if_req, i_if_addr, i_flush,
        input  i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
        output o_if_valid, o_if_rdata, o_if_stall,
        output o_dm_valid, o_dm_rdata, o_dm_stall,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
    );

    modport master (
        output i_if_req, i_if_addr, i_flush,
        output i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata,
        input  o_if_valid, o_if_rdata, o_if_stall,
        input  o_dm_valid, o_dm_rdata, o_dm_stall,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and DM accesses onto one single-port memory, one transaction at a time.
// Define ARB_FAIRNESS_EN to cap consecutive DM grants at MAX_DATA_STREAK while IF waits.
module mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input logic               i_clk,
    input logic               i_reset,
    mem_port_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;
    typedef enum logic {OWN_DM, OWN_IF} owner_t;

    state_t              state, state_next;
    owner_t              owner;
    logic                drop;
    logic                grant_dm, grant_if;
    logic                if_eligible;
    logic                resp_done;
    logic                mem_req_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [BE_W-1:0]     mem_be_q;

    if (MAX_DATA_STREAK < 1) begin : g_bad_streak
        $error("MAX_DATA_STREAK must be at least 1");
    end

`ifdef ARB_FAIRNESS_EN
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    logic [STREAK_W-1:0] streak;
    logic                if_due;
    assign if_due = if_eligible && (streak == STREAK_W'(MAX_DATA_STREAK));
`endif

    assign if_eligible = bus.i_if_req && !bus.i_flush;

    always_comb begin
        state_next = state;
        grant_dm   = 1'b0;
        grant_if   = 1'b0;
        case (state)
            ST_IDLE: begin
`ifdef ARB_FAIRNESS_EN
                if (bus.i_dm_req && !if_due) grant_dm = 1'b1;
                else if (if_eligible)        grant_if = 1'b1;
`else
                if (bus.i_dm_req)     grant_dm = 1'b1;
                else if (if_eligible) grant_if = 1'b1;
`endif
                if (grant_dm || grant_if) state_next = ST_REQ;
            end
            ST_REQ:  if (bus.i_mem_ready)  state_next = ST_RESP;
            ST_RESP: if (bus.i_mem_rvalid) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Request fields stay frozen from grant until the next grant; only o_mem_req drops on accept.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            owner       <= OWN_DM;
            drop        <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            if (grant_dm) begin
                owner       <= OWN_DM;
                drop        <= 1'b0;
                mem_req_q   <= 1'b1;
                mem_we_q    <= bus.i_dm_we;
                mem_addr_q  <= bus.i_dm_addr;
                mem_wdata_q <= bus.i_dm_wdata;
                mem_be_q    <= bus.i_dm_be;
            end else if (grant_if) begin
                owner       <= OWN_IF;
                drop        <= 1'b0;
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= bus.i_if_addr;
                mem_wdata_q <= '0;
                mem_be_q    <= '1;
            end
            if (state == ST_REQ && bus.i_mem_ready) mem_req_q <= 1'b0;
            if (state != ST_IDLE && owner == OWN_IF && bus.i_flush) drop <= 1'b1;
            if (resp_done) drop <= 1'b0;
        end
    end

`ifdef ARB_FAIRNESS_EN
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)      streak <= '0;
        else if (grant_if) streak <= '0;
        else if (grant_dm) streak <= if_eligible ? streak + 1'b1 : '0;
    end
`endif

    // A flush arriving together with the response still discards it.
    assign resp_done      = (state == ST_RESP) && bus.i_mem_rvalid;
    assign bus.o_dm_valid = resp_done && (owner == OWN_DM);
    assign bus.o_if_valid = resp_done && (owner == OWN_IF) && !drop && !bus.i_flush;
    assign bus.o_if_rdata = bus.i_mem_rdata;
    assign bus.o_dm_rdata = bus.i_mem_rdata;
    assign bus.o_if_stall = bus.i_if_req && !bus.o_if_valid;
    assign bus.o_dm_stall = bus.i_dm_req && !bus.o_dm_valid;

    assign bus.o_mem_req   = mem_req_q;
    assign bus.o_mem_we    = mem_we_q;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    assign bus.o_mem_be    = mem_be_q;
endmodule
